if_fetch_stage: RTL and testbench

- Instruction-fetch stage: PC register, synchronous instruction-memory request, and the IF/ID pipeline register.
- Feeds IF_Instruction to the hazard detection unit and ID stage.
- Consumes the hazard unit's Stall and IF_ID_Flush outputs, plus the branch and jump redirects.
- A 1-entry skid buffer absorbs the 1-cycle memory read latency when the pipe stalls.

---
 rtl/if_fetch_stage_if.sv | 26 ++
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a synchronous
// instruction memory.
//   Imem_addr     : fetch address (driven by the fetch stage)
//   Imem_rd_en    : read request this cycle (driven by the fetch stage)
//   Imem_rd_data  : instruction word, valid the cycle after Imem_rd_en
//                   (driven by the memory)
// master = fetch stage side, slave = memory side.
interface if_fetch_stage_if #(
    parameter int PC_WIDTH = 32
) ();
    logic [PC_WIDTH-1:0] Imem_addr;
    logic                Imem_rd_en;
    logic [31:0]         Imem_rd_data;

    modport master (
        output Imem_addr,
        output Imem_rd_en,
        input  Imem_rd_data
    );

    modport slave (
        input  Imem_addr,
        input  Imem_rd_en,
        output Imem_rd_data
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous instruction-memory
// request and the IF/ID pipeline register, with a one-entry skid buffer
// that catches the single response landing in the first stall cycle.
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   Stall                : hold PC and IF/ID
//   IF_ID_Flush          : replace IF/ID with a NOP bubble
//   EX_PC_Branch/target  : branch redirect from EX (highest priority)
//   ID_Jump/target       : jump redirect from ID
//   imem (master)        : Imem_addr / Imem_rd_en / Imem_rd_data bus
//   IF_Instruction/IF_PC/IF_Valid : IF/ID register contents
module if_fetch_stage #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
    parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Stall,
    input  logic                 IF_ID_Flush,
    input  logic                 EX_PC_Branch,
    input  logic [PC_WIDTH-1:0]  EX_Branch_target,
    input  logic                 ID_Jump,
    input  logic [PC_WIDTH-1:0]  ID_Jump_target,
    if_fetch_stage_if.master     imem,
    output logic [31:0]          IF_Instruction,
    output logic [PC_WIDTH-1:0]  IF_PC,
    output logic                 IF_Valid
);

    localparam logic [PC_WIDTH-1:0] PC_STEP       = {{(PC_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [PC_WIDTH-1:0] PC_ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_nxt_s;
    logic                inflight_v_r;
    logic [PC_WIDTH-1:0] inflight_pc_r;
    logic                skid_v_r;
    logic [31:0]         skid_instr_r;
    logic [PC_WIDTH-1:0] skid_pc_r;
    logic [31:0]         if_instr_r;
    logic [PC_WIDTH-1:0] if_pc_r;
    logic                if_valid_r;

    logic                redirect_s;
    logic                issue_s;
    logic                live_s;
    logic                skid_v_stage_s;
    logic                skid_v_nxt_s;
    logic [31:0]         skid_instr_nxt_s;
    logic [PC_WIDTH-1:0] skid_pc_nxt_s;
    logic [31:0]         if_instr_nxt_s;
    logic [PC_WIDTH-1:0] if_pc_nxt_s;
    logic                if_valid_nxt_s;

    // A redirect must fetch even under a stall so the pipe does not wedge
    // on a load-use stall that coincides with a taken branch.
    assign redirect_s   = EX_PC_Branch | ID_Jump;
    assign issue_s      = ~Reset & (~Stall | redirect_s);
    assign live_s       = inflight_v_r;

    assign imem.Imem_addr  = pc_r;
    assign imem.Imem_rd_en = issue_s;

    assign IF_Instruction = if_instr_r;
    assign IF_PC          = if_pc_r;
    assign IF_Valid       = if_valid_r;

    // Next-PC selection: branch > jump > stall > sequential.
    always_comb begin
        pc_nxt_s = pc_r;
        if (EX_PC_Branch) begin
            pc_nxt_s = EX_Branch_target & PC_ALIGN_MASK;
        end else if (ID_Jump) begin
            pc_nxt_s = ID_Jump_target & PC_ALIGN_MASK;
        end else if (Stall) begin
            pc_nxt_s = pc_r;
        end else begin
            pc_nxt_s = pc_r + PC_STEP;
        end
    end

    // IF/ID and skid next-state: flush > stall > skid drain > live > bubble.
    always_comb begin
        if_instr_nxt_s   = if_instr_r;
        if_pc_nxt_s      = if_pc_r;
        if_valid_nxt_s   = if_valid_r;
        skid_v_stage_s   = skid_v_r;
        skid_instr_nxt_s = skid_instr_r;
        skid_pc_nxt_s    = skid_pc_r;
        if (IF_ID_Flush) begin
            if_instr_nxt_s = NOP_INSTR;
            if_valid_nxt_s = 1'b0;
            skid_v_stage_s = 1'b0;
        end else if (Stall) begin
            if (live_s) begin
                skid_v_stage_s   = 1'b1;
                skid_instr_nxt_s = imem.Imem_rd_data;
                skid_pc_nxt_s    = inflight_pc_r;
            end else begin
                skid_v_stage_s   = skid_v_r;
            end
        end else if (skid_v_r) begin
            if_instr_nxt_s = skid_instr_r;
            if_pc_nxt_s    = skid_pc_r;
            if_valid_nxt_s = 1'b1;
            skid_v_stage_s = 1'b0;
        end else if (live_s) begin
            if_instr_nxt_s = imem.Imem_rd_data;
            if_pc_nxt_s    = inflight_pc_r;
            if_valid_nxt_s = 1'b1;
        end else begin
            if_instr_nxt_s = NOP_INSTR;
            if_valid_nxt_s = 1'b0;
        end
    end

    // A redirect discards anything parked in the skid buffer.
    assign skid_v_nxt_s = redirect_s ? 1'b0 : skid_v_stage_s;

    // PC and request-tracking registers; a redirect kills the response
    // of the address issued in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r          <= RESET_PC;
            inflight_v_r  <= 1'b0;
            inflight_pc_r <= {PC_WIDTH{1'b0}};
        end else begin
            pc_r          <= pc_nxt_s;
            inflight_v_r  <= issue_s & ~redirect_s;
            inflight_pc_r <= issue_s ? pc_r : inflight_pc_r;
        end
    end

    // IF/ID pipeline register and skid buffer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if_instr_r   <= NOP_INSTR;
            if_pc_r      <= {PC_WIDTH{1'b0}};
            if_valid_r   <= 1'b0;
            skid_v_r     <= 1'b0;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= {PC_WIDTH{1'b0}};
        end else begin
            if_instr_r   <= if_instr_nxt_s;
            if_pc_r      <= if_pc_nxt_s;
            if_valid_r   <= if_valid_nxt_s;
            skid_v_r     <= skid_v_nxt_s;
            skid_instr_r <= skid_instr_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a directed vector table covering
// the sequential, stall/skid, redirect, wrap and reset corner cases, then
// randomized traffic compared against a queue-based reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        IF_ID_Flush;
    logic        EX_PC_Branch;
    logic [31:0] EX_Branch_target;
    logic        ID_Jump;
    logic [31:0] ID_Jump_target;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic        IF_Valid;

    int n_chk;
    int n_err;
    logic [31:0] mem_xor;

    if_fetch_stage_if #(.PC_WIDTH(32)) imem ();

    if_fetch_stage #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Stall           (Stall),
        .IF_ID_Flush     (IF_ID_Flush),
        .EX_PC_Branch    (EX_PC_Branch),
        .EX_Branch_target(EX_Branch_target),
        .ID_Jump         (ID_Jump),
        .ID_Jump_target  (ID_Jump_target),
        .imem            (imem),
        .IF_Instruction  (IF_Instruction),
        .IF_PC           (IF_PC),
        .IF_Valid        (IF_Valid)
    );

    // Clock generation.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_xor;
    endfunction

    // Synchronous instruction memory: data the cycle after the request.
    always @(posedge Clk) begin
        if (imem.Imem_rd_en) begin
            imem.Imem_rd_data <= mem_word(imem.Imem_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic fl,
                         input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        Reset            = rst;
        Stall            = st;
        IF_ID_Flush      = fl;
        EX_PC_Branch     = br;
        EX_Branch_target = bt;
        ID_Jump          = jp;
        ID_Jump_target   = jt;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, stall, flush, br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] e_addr;
        logic        e_rden;
        logic [31:0] e_instr, e_pc;
        logic        e_valid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic st, input logic fl,
                                input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt,
                                input logic [31:0] ea, input logic er,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic ev);
        vec_t v;
        v.rst = rst; v.stall = st; v.flush = fl; v.br = br; v.bt = bt;
        v.jmp = jp; v.jt = jt; v.e_addr = ea; v.e_rden = er;
        v.e_instr = ei; v.e_pc = ep; v.e_valid = ev;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } resp_t;

    logic [31:0] m_pc;
    resp_t       m_resp_q[$];
    resp_t       m_skid_q[$];
    logic [31:0] m_if_instr;
    logic [31:0] m_if_pc;
    logic        m_if_valid;

    task automatic model_step(input logic rst, input logic st, input logic fl,
                              input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt);
        resp_t r;
        resp_t s;
        logic  have;
        logic  redir;
        if (rst) begin
            m_pc = 32'h0;
            m_resp_q.delete();
            m_skid_q.delete();
            m_if_instr = NOP;
            m_if_pc    = 32'h0;
            m_if_valid = 1'b0;
        end else begin
            redir = br | jp;
            have  = (m_resp_q.size() > 0);
            if (have) r = m_resp_q.pop_front();
            if (fl) begin
                m_if_instr = NOP;
                m_if_valid = 1'b0;
                m_skid_q.delete();
            end else if (st) begin
                if (have) m_skid_q.push_back(r);
            end else if (m_skid_q.size() > 0) begin
                s = m_skid_q.pop_front();
                m_if_instr = s.instr;
                m_if_pc    = s.addr;
                m_if_valid = 1'b1;
            end else if (have) begin
                m_if_instr = r.instr;
                m_if_pc    = r.addr;
                m_if_valid = 1'b1;
            end else begin
                m_if_instr = NOP;
                m_if_valid = 1'b0;
            end
            if (redir) m_skid_q.delete();
            if (!st && !redir) begin
                r.addr  = m_pc;
                r.instr = mem_word(m_pc);
                m_resp_q.push_back(r);
            end
            if (br)      m_pc = {bt[31:2], 2'b00};
            else if (jp) m_pc = {jt[31:2], 2'b00};
            else if (!st) m_pc = m_pc + 32'd4;
        end
    endtask

    // Watchdog: the bench is loop-bounded; this only guards a stuck clock.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st, fl, br, jp, rst;
        logic [31:0] bt, jt;
        n_chk   = 0;
        n_err   = 0;
        mem_xor = 32'h0;
        imem.Imem_rd_data = 32'h0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // rst st fl br bt jmp jt | addr rden | instr pc valid
        tbl.push_back(mk(1,0,0,0,32'h0,  0,32'h0,        32'h000,0, NOP,   32'h000,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h000,1, NOP,   32'h000,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h004,1, 32'h0, 32'h000,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h008,1, 32'h4, 32'h004,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h00C,1, 32'h8, 32'h008,1));
        tbl.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        32'h010,0, 32'h8, 32'h008,1));
        tbl.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        32'h010,0, 32'h8, 32'h008,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h010,1, 32'hC, 32'h00C,1));
        tbl.push_back(mk(0,0,1,1,32'h100,0,32'h0,        32'h014,1, NOP,   32'h00C,0));
        tbl.push_back(mk(0,0,1,0,32'h0,  0,32'h0,        32'h100,1, NOP,   32'h00C,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h104,1, 32'h100,32'h100,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h108,1, 32'h104,32'h104,1));
        tbl.push_back(mk(0,0,1,1,32'h200,1,32'h300,      32'h10C,1, NOP,   32'h104,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h200,1, NOP,   32'h104,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h204,1, 32'h200,32'h200,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h208,1, 32'h204,32'h204,1));
        tbl.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        32'h20C,0, 32'h204,32'h204,1));
        tbl.push_back(mk(0,1,1,1,32'h40, 0,32'h0,        32'h20C,1, NOP,   32'h204,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h040,1, NOP,   32'h204,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h044,1, 32'h40,32'h040,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  1,32'h103,      32'h048,1, 32'h44,32'h044,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h100,1, NOP,   32'h044,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h104,1, 32'h100,32'h100,1));
        tbl.push_back(mk(0,1,0,0,32'h0,  0,32'h0,        32'h108,0, 32'h100,32'h100,1));
        tbl.push_back(mk(1,1,0,0,32'h0,  0,32'h0,        32'h108,0, NOP,   32'h000,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h000,1, NOP,   32'h000,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h004,1, 32'h0, 32'h000,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  1,32'hFFFF_FFFF,32'h008,1, 32'h4, 32'h004,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'hFFFF_FFFC,1, NOP, 32'h004,0));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h000,1, 32'hFFFF_FFFC,32'hFFFF_FFFC,1));
        tbl.push_back(mk(0,0,0,0,32'h0,  0,32'h0,        32'h004,1, 32'h0, 32'h000,1));

        // Two reset edges to bring every register to a known value.
        @(posedge Clk); #1;
        @(posedge Clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].bt,
                  tbl[i].jmp, tbl[i].jt);
            #1;
            chk($sformatf("vec%0d_addr", i), imem.Imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_rden", i), {31'b0, imem.Imem_rd_en}, {31'b0, tbl[i].e_rden});
            @(posedge Clk); #1;
            chk($sformatf("vec%0d_instr", i), IF_Instruction, tbl[i].e_instr);
            chk($sformatf("vec%0d_pc", i), IF_PC, tbl[i].e_pc);
            chk($sformatf("vec%0d_valid", i), {31'b0, IF_Valid}, {31'b0, tbl[i].e_valid});
        end

        // ---------------- randomized phase ----------------
        // Reset first so the model and DUT share a starting point; the data
        // scramble is changed while no request is outstanding.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        mem_xor = 32'h5A5A_0000;
        @(posedge Clk); #1;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 25);
            fl  = ($urandom_range(0, 99) < 12);
            br  = ($urandom_range(0, 99) < 8);
            jp  = ($urandom_range(0, 99) < 8);
            bt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            jt  = 32'($urandom_range(0, 4095));
            drive(rst, st, fl, br, bt, jp, jt);
            #1;
            if (!rst) begin
                chk($sformatf("rnd%0d_addr", c), imem.Imem_addr, m_pc);
            end else begin
                chk($sformatf("rnd%0d_rst_rden", c), {31'b0, imem.Imem_rd_en}, 32'h0);
            end
            chk($sformatf("rnd%0d_rden", c), {31'b0, imem.Imem_rd_en},
                {31'b0, (!rst && (!st || br || jp))});
            @(posedge Clk); #1;
            model_step(rst, st, fl, br, bt, jp, jt);
            chk($sformatf("rnd%0d_instr", c), IF_Instruction, m_if_instr);
            chk($sformatf("rnd%0d_pc", c), IF_PC, m_if_pc);
            chk($sformatf("rnd%0d_valid", c), {31'b0, IF_Valid}, {31'b0, m_if_valid});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
